// File: rtl/truth_table_seq_pkg.sv
// Shared state encoding and width helpers for the truth-table sequencer.
package truth_table_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} tt_state_t;

    function automatic int TT_W(input int n);
        return 1 << n;
    endfunction

    // Counter must reach SETTLE after expiry, so it needs one spare code.
    function automatic int CNT_W(input int s);
        return (s < 1) ? 1 : $clog2(s + 1);
    endfunction

endpackage

// File: rtl/truth_table_seq_if.sv
// Sequencer <-> datapath/controller bundle; expected/mismatch exist only with TT_CHECK_EN.
interface truth_table_seq_if #(parameter int N_IN = 2);
    import truth_table_pkg::*;
    localparam int TTW = TT_W(N_IN);

    logic            start;
    logic            busy;
    logic            done;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic [TTW-1:0]  tt;
`ifdef TT_CHECK_EN
    logic [TTW-1:0]  expected;
    logic            mismatch;

    modport master (output start, dut_out, expected, input busy, done, dut_in, tt, mismatch);
    modport slave  (input start, dut_out, expected, output busy, done, dut_in, tt, mismatch);
`else
    modport master (output start, dut_out, input busy, done, dut_in, tt);
    modport slave  (input start, dut_out, output busy, done, dut_in, tt);
`endif
endinterface

// File: rtl/truth_table_seq_settle_timer.sv
// Settle counter: cleared while load is high, counts up otherwise, expire at SETTLE-1.
module tt_settle_timer
    import truth_table_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int             CW   = CNT_W(SETTLE);
    localparam logic [CW-1:0]  LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]  CMAX = CW'(SETTLE);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load)
            r_cnt <= '0;
        else if (r_cnt != CMAX)
            r_cnt <= r_cnt + 1'b1;
    end

    assign expire = (r_cnt == LAST);
endmodule

// File: rtl/truth_table_seq.sv
// Walks dut_in through all codes, samples dut_out into tt after SETTLE cycles each.
// Optional TT_CHECK_EN adds a compare of the finished table against bus.expected.
module truth_table_seq
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    truth_table_seq_if.slave  bus
);
    localparam int              TTW      = TT_W(N_IN);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TTW - 1);

    tt_state_t       r_state, w_state_nxt;
    logic [N_IN-1:0] r_idx;
    logic [TTW-1:0]  r_tt, w_tt_nxt;
    logic            w_load, w_expire, w_accept, w_last;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == SAMPLE) && (r_idx == IDX_LAST);

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tt_nxt    = r_tt;
        w_load      = 1'b1;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = DRIVE;
                    w_tt_nxt    = '0;
                end
            end
            DRIVE: begin
                w_load = 1'b0;
                if (w_expire)
                    w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                w_tt_nxt[r_idx] = bus.dut_out;
                w_state_nxt     = (r_idx == IDX_LAST) ? DONE : DRIVE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_tt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tt    <= w_tt_nxt;
            if (w_accept)
                r_idx <= '0;
            else if ((r_state == SAMPLE) && !w_last)
                r_idx <= r_idx + 1'b1;
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.dut_in = ((r_state == DRIVE) || (r_state == SAMPLE)) ? r_idx : '0;
    assign bus.tt     = r_tt;

`ifdef TT_CHECK_EN
    logic [TTW-1:0] r_expected;
    logic           r_mismatch;

    // Compare against the next-state table so the flag lands with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_expected <= bus.expected;
            r_mismatch <= 1'b0;
        end else if (w_last) begin
            r_mismatch <= |(w_tt_nxt ^ r_expected);
        end
    end

    assign bus.mismatch = r_mismatch;
`endif
endmodule

// File: tb/tb_truth_table_seq.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=3) driving s = x | ~y.
module tb_truth_table_seq;
    import truth_table_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    truth_table_seq_if #(.N_IN(2)) bus1 ();
    truth_table_seq_if #(.N_IN(2)) bus3 ();

    assign bus1.dut_out = bus1.dut_in[1] | ~bus1.dut_in[0];
    assign bus3.dut_out = bus3.dut_in[1] | ~bus3.dut_in[0];

    truth_table_seq #(.N_IN(2), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    truth_table_seq #(.N_IN(2), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic set_start(input int s, input logic v);
        if (s == 1) bus1.start = v;
        else        bus3.start = v;
    endtask

    // One full run; checks {busy,done,dut_in} every cycle, then tt and the done count.
    task automatic run_check(input string name, input int s, input int repulse_at);
        int         n      = 4 * (s + 1);
        int         n_done = 0;
        logic [3:0] obs, exp_v, tt_o;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        for (int e = 0; e <= n + 1; e++) begin
            @(negedge clk);
            set_start(s, (e + 1 == repulse_at));
            obs  = (s == 1) ? {bus1.busy, bus1.done, bus1.dut_in}
                            : {bus3.busy, bus3.done, bus3.dut_in};
            tt_o = (s == 1) ? bus1.tt : bus3.tt;
            if (e < n)       exp_v = {2'b10, 2'(e / (s + 1))};
            else if (e == n) exp_v = 4'b1100;
            else             exp_v = 4'b0000;
            if (obs[2]) n_done++;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s e=%0d busy/done/dut_in got=%b exp=%b", name, e, obs, exp_v);
            end
        end
        total++;
        if (tt_o !== 4'b1101) begin
            bad++;
            $display("FAIL %s tt got=%b exp=1101", name, tt_o);
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d exp=1", name, n_done);
        end
    endtask

    task automatic test_reset;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
`ifdef TT_CHECK_EN
        bus1.expected = 4'b1101;
        bus3.expected = 4'b1101;
`endif
        @(negedge clk);
        total++;
        if ({bus1.busy, bus1.done, bus1.dut_in, bus1.tt} !== 8'h00) begin
            bad++;
            $display("FAIL reset_dut1 got=%b exp=00000000",
                     {bus1.busy, bus1.done, bus1.dut_in, bus1.tt});
        end
        total++;
        if ({bus3.busy, bus3.done, bus3.dut_in, bus3.tt} !== 8'h00) begin
            bad++;
            $display("FAIL reset_dut3 got=%b exp=00000000",
                     {bus3.busy, bus3.done, bus3.dut_in, bus3.tt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus1.busy, bus1.done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset busy/done got=%b exp=00", {bus1.busy, bus1.done});
        end
    endtask

    task automatic test_settle1;
        run_check("settle1", 1, -1);
    endtask

    task automatic test_settle3;
        run_check("settle3", 3, -1);
    endtask

    task automatic test_restart_ignored;
        run_check("restart_ignored", 1, 3);
    endtask

    task automatic test_midrun_reset;
        int n_done = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.dut_in, bus1.tt} !== 7'b1100001) begin
            bad++;
            $display("FAIL pre_reset busy/dut_in/tt got=%b exp=1100001",
                     {bus1.busy, bus1.dut_in, bus1.tt});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus1.busy, bus1.done, bus1.dut_in, bus1.tt} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b exp=00000000",
                     {bus1.busy, bus1.done, bus1.dut_in, bus1.tt});
        end
        repeat (3) begin
            @(negedge clk);
            if (bus1.done) n_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus1.done) n_done++;
        end
        total++;
        if (n_done != 0 || bus1.busy !== 1'b0) begin
            bad++;
            $display("FAIL aborted_run done_count=%0d busy=%b exp 0 and 0", n_done, bus1.busy);
        end
        run_check("after_reset", 1, -1);
    endtask

    task automatic test_back_to_back;
        int         n_done = 0;
        int         pos;
        logic [3:0] obs, exp_v;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            pos = e % 10;
            obs = {bus1.busy, bus1.done, bus1.dut_in};
            if (pos < 8)       exp_v = {2'b10, 2'(pos / 2)};
            else if (pos == 8) exp_v = 4'b1100;
            else               exp_v = 4'b0000;
            if (obs[2]) n_done++;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL back_to_back e=%0d busy/done/dut_in got=%b exp=%b", e, obs, exp_v);
            end
            if (e == 19) bus1.start = 1'b0;
        end
        total++;
        if (n_done != 2 || bus1.tt !== 4'b1101) begin
            bad++;
            $display("FAIL back_to_back done_count=%0d tt=%b exp 2 and 1101", n_done, bus1.tt);
        end
        @(negedge clk);
        total++;
        if (bus1.busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back stop busy got=%b exp=0", bus1.busy);
        end
    endtask

    task automatic test_check_en;
`ifdef TT_CHECK_EN
        logic [3:0] exp_tab [2];
        logic       exp_mm  [2];
        exp_tab[0] = 4'b1101; exp_mm[0] = 1'b0;
        exp_tab[1] = 4'b1111; exp_mm[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            bus1.expected = exp_tab[r];
            bus1.start    = 1'b1;
            @(posedge clk);
            for (int e = 0; e <= 9; e++) begin
                @(negedge clk);
                bus1.start = 1'b0;
                if (e == 7) begin
                    total++;
                    if (bus1.mismatch !== 1'b0) begin
                        bad++;
                        $display("FAIL mismatch_before_done r=%0d got=%b exp=0", r, bus1.mismatch);
                    end
                end
                if (e == 8) begin
                    total++;
                    if ({bus1.done, bus1.mismatch} !== {1'b1, exp_mm[r]}) begin
                        bad++;
                        $display("FAIL mismatch_at_done r=%0d done/mismatch got=%b exp=%b",
                                 r, {bus1.done, bus1.mismatch}, {1'b1, exp_mm[r]});
                    end
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_settle1();
        test_settle3();
        test_restart_ignored();
        test_midrun_reset();
        test_back_to_back();
        test_check_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
